// File: rtl/duty_ramp_ctrl.sv
// duty_ramp_ctrl
// Ramps the PWM compare value toward a requested duty, one saturating step
// per ramp tick. A direction change first brakes the duty to zero, then
// holds zero for a dead time before the new direction is applied.
//
// Ports
//   i_clk        single clock, rising edge
//   i_reset      synchronous, active-high reset
//   i_en         motor enable (0 forces the effective target to 0)
//   i_target     requested duty, 0..255
//   i_dir        requested rotation direction
//   i_step       duty change per ramp tick, 0..15
//   o_ocr        registered duty for the PWM compare input
//   o_dir        registered direction for the motor bridge
//   o_at_target  in RUN, duty equals the effective target and direction matches
//   o_state      RUN=0, BRAKE=1, DEAD=2
//
// state | meaning
// RUN   | ramp o_ocr toward the effective target on each tick
// BRAKE | ramp o_ocr down to 0 before a direction change
// DEAD  | hold o_ocr at 0 for DEAD_TICKS ticks, then apply i_dir

module duty_ramp_ctrl #(
  parameter int TICK_DIV   = 100000,
  parameter int DEAD_TICKS = 50
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_en,
  input  logic [7:0] i_target,
  input  logic       i_dir,
  input  logic [3:0] i_step,
  output logic [7:0] o_ocr,
  output logic       o_dir,
  output logic       o_at_target,
  output logic [1:0] o_state
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam int DW = (DEAD_TICKS > 2) ? $clog2(DEAD_TICKS) : 1;
  localparam logic [DW-1:0] DEAD_LAST = (DEAD_TICKS > 0) ? DW'(DEAD_TICKS - 1) : '0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_BRAKE = 2'd1,
    ST_DEAD  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      ocr_q, ocr_d;
  logic            dir_q, dir_d;
  logic [CW-1:0]   tick_cnt_q;
  logic [DW-1:0]   dead_cnt_q, dead_cnt_d;

  logic            tick;
  logic [7:0]      eff;
  logic [8:0]      up_sum;
  logic [8:0]      dn_diff;
  logic [7:0]      up_val;
  logic [7:0]      dn_to_eff;
  logic [7:0]      dn_to_zero;

  assign tick = (tick_cnt_q == TICK_LAST);
  assign eff  = i_en ? i_target : 8'd0;

  // Ninth bit catches carry/borrow so the duty clamps instead of wrapping.
  assign up_sum     = {1'b0, ocr_q} + {5'd0, i_step};
  assign dn_diff    = {1'b0, ocr_q} - {5'd0, i_step};
  assign up_val     = (up_sum > {1'b0, eff}) ? eff : up_sum[7:0];
  assign dn_to_eff  = (dn_diff[8] || (dn_diff[7:0] < eff)) ? eff : dn_diff[7:0];
  assign dn_to_zero = dn_diff[8] ? 8'd0 : dn_diff[7:0];

  // Tick counter free-runs regardless of state so tick phase is stable.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_RUN;
      ocr_q      <= 8'd0;
      dir_q      <= 1'b0;
      tick_cnt_q <= '0;
      dead_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ocr_q      <= ocr_d;
      dir_q      <= dir_d;
      tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
      dead_cnt_q <= dead_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ocr_d      = ocr_q;
    dir_d      = dir_q;
    dead_cnt_d = dead_cnt_q;
    unique case (state_q)
      ST_RUN: begin
        // A pending reversal wins over the ramp step in the same cycle.
        if (i_dir != dir_q) begin
          dead_cnt_d = '0;
          state_d    = (ocr_q != 8'd0) ? ST_BRAKE : ST_DEAD;
        end else if (tick) begin
          if (ocr_q < eff)
            ocr_d = up_val;
          else if (ocr_q > eff)
            ocr_d = dn_to_eff;
        end
      end
      ST_BRAKE: begin
        if (i_dir == dir_q) begin
          state_d = ST_RUN;
        end else if (ocr_q == 8'd0) begin
          dead_cnt_d = '0;
          state_d    = ST_DEAD;
        end else if (tick) begin
          ocr_d = dn_to_zero;
        end
      end
      ST_DEAD: begin
        ocr_d = 8'd0;
        if (DEAD_TICKS == 0) begin
          dir_d   = i_dir;
          state_d = ST_RUN;
        end else if (tick) begin
          if (dead_cnt_q == DEAD_LAST) begin
            dir_d   = i_dir;
            state_d = ST_RUN;
          end else begin
            dead_cnt_d = dead_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign o_ocr       = ocr_q;
  assign o_dir       = dir_q;
  assign o_state     = state_q;
  assign o_at_target = (state_q == ST_RUN) && (ocr_q == eff) && (dir_q == i_dir);

endmodule

// File: tb/tb_duty_ramp_ctrl.sv
module tb_duty_ramp_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] target;
  logic       dir;
  logic [3:0] step;
  logic [7:0] ocr;
  logic       dir_o;
  logic       at_tgt;
  logic [1:0] state;

  int n_chk  = 0;
  int n_fail = 0;

  // Expected tick phase: ramp ticks land on every 4th edge after a reset edge.
  logic [1:0] ph;

  duty_ramp_ctrl #(.TICK_DIV(4), .DEAD_TICKS(2)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_en        (en),
    .i_target    (target),
    .i_dir       (dir),
    .i_step      (step),
    .o_ocr       (ocr),
    .o_dir       (dir_o),
    .o_at_target (at_tgt),
    .o_state     (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) ph <= 2'd0;
    else     ph <= ph + 2'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic next_tick();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (ph != 2'd0 && n < 8);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; target = 8'd10; dir = 1'b0; step = 4'd3;
    cyc(2);
    rst = 1'b0;
    chk("rst_ocr",   ocr,    0);
    chk("rst_dir",   dir_o,  0);
    chk("rst_state", state,  0);
    chk("rst_at_tgt_eff10", at_tgt, 0);
    en = 1'b0; #1;
    chk("rst_at_tgt_eff0", at_tgt, 1);
    en = 1'b1;

    // ramp up 3,6,9,10
    next_tick(); chk("up_1", ocr, 3);
    cyc(1);      chk("up_hold", ocr, 3);
    next_tick(); chk("up_2", ocr, 6);
    next_tick(); chk("up_3", ocr, 9);
    chk("up_3_at_tgt", at_tgt, 0);
    next_tick(); chk("up_4", ocr, 10);
    chk("up_4_at_tgt", at_tgt, 1);
    next_tick(); chk("up_sat", ocr, 10);

    // saturating ramp down 6,2,0
    target = 8'd0; step = 4'd4;
    next_tick(); chk("dn_1", ocr, 6);
    next_tick(); chk("dn_2", ocr, 2);
    next_tick(); chk("dn_3", ocr, 0);
    next_tick(); chk("dn_nowrap", ocr, 0);
    chk("dn_at_tgt", at_tgt, 1);

    // reach 6 then reverse
    target = 8'd6; step = 4'd3;
    next_tick(); next_tick(); chk("rev_pre", ocr, 6);
    step = 4'd2; dir = 1'b1;
    cyc(1);
    chk("rev_brake_state", state, 1);
    chk("rev_brake_ocr",   ocr,   6);
    next_tick(); chk("brk_1", ocr, 4);
    next_tick(); chk("brk_2", ocr, 2);
    next_tick(); chk("brk_3", ocr, 0);
    chk("brk_3_state", state, 1);
    cyc(1);
    chk("dead_state", state, 2);
    chk("dead_dir",   dir_o, 0);
    dir = 1'b0; cyc(1); dir = 1'b1;
    chk("dead_ignore_dir", state, 2);
    next_tick();
    chk("dead_tick1_state", state, 2);
    chk("dead_tick1_dir",   dir_o, 0);
    chk("dead_tick1_ocr",   ocr,   0);
    next_tick();
    chk("dead_exit_state", state, 0);
    chk("dead_exit_dir",   dir_o, 1);
    chk("dead_exit_ocr",   ocr,   0);
    next_tick(); chk("rev_ramp", ocr, 2);
    chk("rev_ramp_at_tgt", at_tgt, 0);

    // cancelled reversal from ocr=4
    next_tick(); chk("can_pre", ocr, 4);
    dir = 1'b0;
    cyc(1); chk("can_brake", state, 1);
    dir = 1'b1;
    cyc(1);
    chk("can_state", state, 0);
    chk("can_ocr",   ocr,   4);
    chk("can_dir",   dir_o, 1);
    next_tick(); chk("can_resume", ocr, 6);
    chk("can_at_tgt", at_tgt, 1);

    // reset mid-BRAKE at ocr=9
    target = 8'd9; step = 4'd3;
    next_tick(); chk("mid_pre", ocr, 9);
    dir = 1'b0;
    cyc(1); chk("mid_brake", state, 1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("mid_rst_ocr",   ocr,   0);
    chk("mid_rst_dir",   dir_o, 0);
    chk("mid_rst_state", state, 0);
    cyc(3); chk("post_rst_no_tick", ocr, 0);
    cyc(1); chk("post_rst_tick4",   ocr, 3);

    // disable and hold
    target = 8'd8; step = 4'd4;
    next_tick(); chk("dis_pre1", ocr, 7);
    next_tick(); chk("dis_pre2", ocr, 8);
    en = 1'b0;
    next_tick(); chk("dis_1", ocr, 4);
    next_tick(); chk("dis_2", ocr, 0);
    en = 1'b1; step = 4'd0; target = 8'd200;
    next_tick(); chk("hold_ocr", ocr, 0);
    chk("hold_at_tgt", at_tgt, 0);
    next_tick(); chk("hold_ocr2", ocr, 0);

    // upward saturation at eff and at 255 (no 8-bit carry wrap)
    step = 4'd15; target = 8'd5;
    next_tick(); chk("upsat_eff", ocr, 5);
    target = 8'd255;
    for (int i = 0; i < 16; i++) next_tick();
    chk("top_245", ocr, 245);
    next_tick(); chk("top_255", ocr, 255);
    chk("top_at_tgt", at_tgt, 1);
    next_tick(); chk("top_hold", ocr, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
